vppm_slicer_demod: RTL
======================

# vppm_slicer_demod

Downstream stage of the FIR receive filter in the VPPM receiver chain. Consumes the filtered signed sample stream and slices it to a binary light/dark level with a threshold comparator. Locks symbol timing on the first rising edge and decides each VPPM bit by comparing high-sample counts in the two symbol halves. Emits one decoded bit per symbol with a valid strobe, a duty estimate and lock/loss-of-signal status.

## Interface
- NBITS1, 16, width of the signed filtered input sample
- SYM_LEN, 32, samples per VPPM symbol; even, 4..63
- NBCNT, 6, width of sample-index, half-count and duty counters; 2^NBCNT > SYM_LEN
- THR_HI, 2000, signed slicer upper threshold
- THR_LO, 1000, signed slicer lower threshold (hysteresis build only); THR_LO ≤ THR_HI
- LOS_SYMS, 4, consecutive flat symbols that drop lock (1..15)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- sample_in  in  NBITS1  signed filtered sample (FIR filteredOut)
- sample_valid  in  1  one-cycle strobe, sample_in is new this cycle
- bit_out  out  1  decoded bit, held until next bit_valid
- bit_valid  out  1  one-cycle strobe, bit_out/duty updated
- duty  out  NBCNT  high-sample count of last symbol (h1+h2)
- sym_err  out  1  one-cycle strobe with bit_valid when h1 == h2
- locked  out  1  high while in TRACK
- los  out  1  one-cycle strobe when lock is dropped

## Operation
- Reset (rst_n low, any time, async): state HUNT; sliced, sliced_prev, idx, h1, h2, los_cnt = 0; all outputs 0. Takes effect mid-symbol; partial symbol discarded.
- Cycles with sample_valid = 0: no register changes except strobes clearing to 0.
- Slicer, on each valid sample: sliced = 1 if sample_in ≥ THR_HI; see Configuration for clear rule. Comparison is signed. sliced_prev ← previous sliced.
- HUNT: on a valid sample with sliced = 1 and sliced_prev = 0 → TRACK; this sample is index 0, h1 ← 1, h2 ← 0, idx ← 1. locked asserts the next cycle.
- TRACK, each valid sample: if idx < SYM_LEN/2, h1 += sliced, else h2 += sliced. If idx = SYM_LEN−1: register result, idx ← 0, h1, h2 ← 0 (counts include this sample); else idx += 1.
- Decision: bit_out = (h2 > h1); tie gives bit_out = 0 and sym_err = 1; duty = h1 + h2.
- Loss of signal: symbol with duty = 0 or duty = SYM_LEN increments los_cnt, otherwise los_cnt ← 0. If los_cnt reaches LOS_SYMS: bit_valid still issued for that symbol, los pulses with it, state → HUNT, los_cnt ← 0, locked drops next cycle.
- After return to HUNT, sliced_prev is kept, so a signal stuck high needs a fall then a rise to relock.

## Timing
- Slicer and counters register on the sample_valid cycle.
- bit_valid, sym_err, los: asserted exactly 1 cycle after the sample_valid carrying sample index SYM_LEN−1; high for 1 cycle.
- Back-to-back sample_valid (every cycle) supported; no backpressure.
- Minimum gap between bit_valid pulses: SYM_LEN cycles.

## Configuration
- VPPM_HYST_EN defined: hysteresis slicer; sliced sets at sample_in ≥ THR_HI, clears at sample_in < THR_LO, holds in between.
- VPPM_HYST_EN undefined: single threshold; sliced = (sample_in ≥ THR_HI) each valid sample; THR_LO unused.

## Test plan
- Defaults, VPPM_HYST_EN: 8 samples −500, then symbols of 16×3000 + 16×0 → lock on first 3000; each bit_valid has bit_out = 0, duty = 16, sym_err = 0.
- Locked, then symbol 16×0 + 16×3000 → bit_out = 1, duty = 16; symbol 8×3000 + 16×0 + 8×3000 → bit_out = 0, sym_err = 1, duty = 16.
- Locked, then 4 symbols of all 0 → 4 bit_valid with duty = 0; los pulses with the 4th; locked = 0 the next cycle.
- Hysteresis: alternate 1500/2500/1500 after lock → sliced stays 1 with VPPM_HYST_EN; toggles (duty changes) without it.
- sample_valid only every 5th cycle → identical bits as back-to-back case; bit_valid 1 cycle after each 32nd valid.
- Assert rst_n low at idx = 10 of a locked symbol → all outputs 0 immediately; after release, relock only on a new rising edge.

Source files
------------

// File: rtl/vppm_slicer_demod.sv
// ---------------------------------------------------------------------------
// vppm_slicer_demod
//
// Purpose: slices the filtered signed VPPM sample stream into light/dark
// levels, locks symbol timing on the first rising edge, and decides each
// VPPM bit by comparing the high-sample counts of the two symbol halves.
// Produces one bit per symbol with a valid strobe, a duty estimate and
// lock / loss-of-signal status.
//
// Configuration macro: VPPM_HYST_EN
//   defined   -> hysteresis slicer (set at >= THR_HI, clear at < THR_LO)
//   undefined -> single threshold slicer (>= THR_HI), THR_LO unused
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   sample_in    in   signed filtered sample (NBITS1 bits)
//   sample_valid in   one-cycle strobe, sample_in is new
//   bit_out      out  decoded bit, held until the next bit_valid
//   bit_valid    out  one-cycle strobe, bit_out/duty updated
//   duty         out  high-sample count of the last symbol (NBCNT bits)
//   sym_err      out  one-cycle strobe with bit_valid when halves tie
//   locked       out  high while tracking symbols
//   los          out  one-cycle strobe when lock is dropped
// ---------------------------------------------------------------------------
module vppm_slicer_demod #(
  parameter int NBITS1   = 16,
  parameter int SYM_LEN  = 32,
  parameter int NBCNT    = 6,
  parameter int THR_HI   = 2000,
  parameter int THR_LO   = 1000,
  parameter int LOS_SYMS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NBITS1-1:0] sample_in,
  input  logic              sample_valid,
  output logic              bit_out,
  output logic              bit_valid,
  output logic [NBCNT-1:0]  duty,
  output logic              sym_err,
  output logic              locked,
  output logic              los
);

  localparam logic [NBCNT-1:0]         LAST_IDX = NBCNT'(SYM_LEN - 1);
  localparam logic [NBCNT-1:0]         HALF_IDX = NBCNT'(SYM_LEN / 2);
  localparam logic [NBCNT-1:0]         FULL_CNT = NBCNT'(SYM_LEN);
  localparam logic [3:0]               LOS_LIM  = 4'(LOS_SYMS);
  localparam logic signed [NBITS1-1:0] THR_HI_S = NBITS1'(THR_HI);
`ifdef VPPM_HYST_EN
  localparam logic signed [NBITS1-1:0] THR_LO_S = NBITS1'(THR_LO);
`endif

  // Reject parameter sets the counters cannot represent.
  if ((SYM_LEN % 2) != 0 || SYM_LEN < 4 || SYM_LEN > 63 ||
      (2 ** NBCNT) <= SYM_LEN || THR_LO > THR_HI ||
      LOS_SYMS < 1 || LOS_SYMS > 15) begin : g_param_check
    $error("vppm_slicer_demod: illegal parameter set");
  end

  typedef enum logic {HUNT, TRACK} state_t;

  state_t             state_q, state_d;
  logic               sliced_q, sliced_d;
  logic [NBCNT-1:0]   idx_q, idx_d;
  logic [NBCNT-1:0]   h1_q, h1_d;
  logic [NBCNT-1:0]   h2_q, h2_d;
  logic [3:0]         los_cnt_q, los_cnt_d;
  logic               bit_out_q, bit_out_d;
  logic               bit_valid_q, bit_valid_d;
  logic [NBCNT-1:0]   duty_q, duty_d;
  logic               sym_err_q, sym_err_d;
  logic               los_q, los_d;

  logic signed [NBITS1-1:0] sample_s;
  logic [NBCNT-1:0]   h1_acc, h2_acc, sym_duty;
  logic [3:0]         flat_cnt;

  assign sample_s = $signed(sample_in);

  // Slicer. sliced_q always holds the previous sample's level, which is
  // exactly what the rising-edge detector in HUNT needs.
  always_comb begin
    sliced_d = sliced_q;
    if (sample_valid) begin
`ifdef VPPM_HYST_EN
      if (sample_s >= THR_HI_S) begin
        sliced_d = 1'b1;
      end else if (sample_s < THR_LO_S) begin
        sliced_d = 1'b0;
      end
`else
      sliced_d = (sample_s >= THR_HI_S);
`endif
    end
  end

  // Symbol counters, including the current sample, so the final sample of a
  // symbol is already part of the decision.
  always_comb begin
    h1_acc = h1_q;
    h2_acc = h2_q;
    if (idx_q < HALF_IDX) begin
      h1_acc = h1_q + NBCNT'(sliced_d);
    end else begin
      h2_acc = h2_q + NBCNT'(sliced_d);
    end
    sym_duty = h1_acc + h2_acc;
    flat_cnt = ((sym_duty == '0) || (sym_duty == FULL_CNT)) ? los_cnt_q + 4'd1 : 4'd0;
  end

  // Next-state logic. Strobes default low; everything else holds unless a
  // valid sample arrives.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    h1_d        = h1_q;
    h2_d        = h2_q;
    los_cnt_d   = los_cnt_q;
    bit_out_d   = bit_out_q;
    duty_d      = duty_q;
    bit_valid_d = 1'b0;
    sym_err_d   = 1'b0;
    los_d       = 1'b0;
    if (sample_valid) begin
      unique case (state_q)
        HUNT: begin
          // The rising-edge sample becomes index 0 of the first symbol.
          if (sliced_d && !sliced_q) begin
            state_d = TRACK;
            idx_d   = NBCNT'(1);
            h1_d    = NBCNT'(1);
            h2_d    = '0;
          end
        end
        TRACK: begin
          if (idx_q == LAST_IDX) begin
            idx_d       = '0;
            h1_d        = '0;
            h2_d        = '0;
            bit_valid_d = 1'b1;
            bit_out_d   = (h2_acc > h1_acc);
            sym_err_d   = (h2_acc == h1_acc);
            duty_d      = sym_duty;
            los_cnt_d   = flat_cnt;
            if (flat_cnt == LOS_LIM) begin
              los_d     = 1'b1;
              los_cnt_d = '0;
              state_d   = HUNT;
            end
          end else begin
            idx_d = idx_q + NBCNT'(1);
            h1_d  = h1_acc;
            h2_d  = h2_acc;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      sliced_q    <= 1'b0;
      idx_q       <= '0;
      h1_q        <= '0;
      h2_q        <= '0;
      los_cnt_q   <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      duty_q      <= '0;
      sym_err_q   <= 1'b0;
      los_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sliced_q    <= sliced_d;
      idx_q       <= idx_d;
      h1_q        <= h1_d;
      h2_q        <= h2_d;
      los_cnt_q   <= los_cnt_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      duty_q      <= duty_d;
      sym_err_q   <= sym_err_d;
      los_q       <= los_d;
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign duty      = duty_q;
  assign sym_err   = sym_err_q;
  assign los       = los_q;
  assign locked    = (state_q == TRACK);

endmodule
